pll_lock_sequencer: RTL and testbench
=====================================

// Module: pll_lock_sequencer
// PURPOSE
//  Sequences the ECP5 EHXPLLL on the 25 MHz reference clock: pulses the PLL reset, waits for LOCK with timeout/retry,
//  qualifies lock for a stable window, then releases the SoC reset. On lock loss or forced relock it re-arms.
//  Sits between the board oscillator and the PLL wrapper; sys_rst is the root reset fed to per-domain synchronisers.
// PARAMETERS
//  PLL_RST_CYCLES  16     cycles pll_rst is held high per attempt (>=1)
//  LOCK_TIMEOUT    65536  cycles in WAIT_LOCK without lock before retry (>=2)
//  STABLE_CYCLES   1024   consecutive synced-lock cycles required before release (>=1)
//  SYNC_STAGES     2      flops on pll_locked_async (>=2)
//  RETRY_W         8      width of retry_count
//  STEP_PULSE      4      phasestep high/low cycles (PLL_PHASE_STEP_EN only, >=1)
// PORTS
//  clk              in   1        25 MHz reference clock, sole clock
//  rst              in   1        synchronous, active-high
//  pll_locked_async in   1        EHXPLLL LOCK, asynchronous to clk
//  relock_req       in   1        1-cycle pulse: force full re-lock sequence
//  pll_rst          out  1        to EHXPLLL RST
//  sys_rst          out  1        root SoC reset, active-high
//  ready            out  1        high only in RUN
//  retry_count      out  RETRY_W  lock-timeout count, saturating
//  step_req         in   1        [macro] request one phase step
//  step_sel         in   2        [macro] output select for step
//  step_dir         in   1        [macro] step direction
//  step_busy        out  1        [macro] step in progress
//  pll_phasesel     out  2        [macro] to PHASESEL1:0
//  pll_phasedir     out  1        [macro] to PHASEDIR
//  pll_phasestep    out  1        [macro] to PHASESTEP
// BEHAVIOUR
//  - All outputs registered. Reset values: pll_rst=1 sys_rst=1 ready=0 retry_count=0 step_busy=0 pll_phase*=0.
//  - lock_s = pll_locked_async after SYNC_STAGES flops (sync flops reset to 0); logic below uses lock_s only.
//  - FSM: PRST -> WAIT_LOCK -> STABLE -> RUN; rst forces PRST, counter cleared, from any state mid-sequence.
//  - PRST: pll_rst=1, sys_rst=1; exactly PLL_RST_CYCLES cycles, then WAIT_LOCK (pll_rst=0 on that edge).
//  - WAIT_LOCK: lock_s=1 -> STABLE; counter reaching LOCK_TIMEOUT-1 with lock_s=0 -> PRST, retry_count+1 (sat at all-ones).
//  - STABLE: lock_s=0 -> WAIT_LOCK with timeout counter restarted, no retry increment;
//    STABLE_CYCLES consecutive lock_s=1 -> RUN.
//  - Latency: first edge sampling pll_locked_async=1 to sys_rst=0 is SYNC_STAGES+STABLE_CYCLES+1 cycles.
//  - RUN: sys_rst=0, ready=1. lock_s=0 -> PRST; sys_rst=1, ready=0 on the next edge.
//  - relock_req in WAIT_LOCK/STABLE/RUN -> PRST, no retry increment; ignored in PRST. Simultaneous with lock loss: same.
//  - Timeout and relock_req same cycle: relock wins, no increment. Single counter, width clog2(max param).
// CONFIGURATION
//  PLL_PHASE_STEP_EN defined: step ports present.
//    - step_req accepted only in RUN with step_busy=0: latch sel/dir to pll_phasesel/dir, step_busy=1.
//    - pll_phasestep high STEP_PULSE cycles, then low STEP_PULSE cycles, then step_busy=0.
//    - step_req while busy or outside RUN ignored. Leaving RUN mid-step: pll_phasestep=0, step_busy=0 next edge.
//    - pll_phasesel/dir hold stable throughout step.
//  Not defined: step ports absent; wrapper ties PHASESEL=0, PHASEDIR=1, PHASESTEP=1 statically.
// TESTING  (PLL_RST_CYCLES=4 LOCK_TIMEOUT=32 STABLE_CYCLES=8 SYNC_STAGES=2)
//  - rst release, lock rises at cycle 10 -> pll_rst high cycles 0-3; sys_rst falls 11 cycles after lock sampled; ready=1.
//  - lock never rises -> pll_rst re-pulses every 36 cycles; retry_count 1,2,3..; RETRY_W=2 saturates at 3.
//  - lock glitches low for 1 cycle at STABLE count 5 -> back to WAIT_LOCK; release only after 8 fresh cycles; no retry.
//  - RUN, lock drops -> sys_rst=1, ready=0 one cycle after lock_s falls; pll_rst pulse of 4 cycles follows.
//  - relock_req in RUN -> PRST, retry_count unchanged; rst asserted mid-STABLE -> all outputs at reset values next edge.
//  - [macro] step_req sel=2 dir=1 in RUN -> phasestep 4 high/4 low, busy 8 cycles; 2nd req while busy ignored.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
// Brings up the ECP5 EHXPLLL from the 25 MHz reference clock: pulses the PLL
// reset, waits for LOCK (with timeout and retry), qualifies lock over a stable
// window and only then releases the root SoC reset. Lock loss or a relock
// request restarts the whole sequence.
// Optional feature macro: PLL_PHASE_STEP_EN adds the dynamic phase-step ports
// (step_req/step_sel/step_dir in, step_busy/pll_phasesel/pll_phasedir/
// pll_phasestep out). Without it the wrapper ties the PLL phase pins statically.
module pll_lock_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int SYNC_STAGES    = 2,
  parameter int RETRY_W        = 8
`ifdef PLL_PHASE_STEP_EN
  , parameter int STEP_PULSE   = 4
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_locked_async,
  input  logic               relock_req,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic [RETRY_W-1:0] retry_count
`ifdef PLL_PHASE_STEP_EN
  ,
  input  logic               step_req,
  input  logic [1:0]         step_sel,
  input  logic               step_dir,
  output logic               step_busy,
  output logic [1:0]         pll_phasesel,
  output logic               pll_phasedir,
  output logic               pll_phasestep
`endif
);

  // One shared counter serves all timed states, so it must hold the largest
  // terminal value (STABLE compares against STABLE_CYCLES itself).
  localparam int MAX_AB  = (PLL_RST_CYCLES - 1 > LOCK_TIMEOUT - 1) ? PLL_RST_CYCLES - 1 : LOCK_TIMEOUT - 1;
  localparam int MAX_CNT = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0]   PRST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   WAIT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STAB_LAST = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = {RETRY_W{1'b1}};
  localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);

  typedef enum logic [1:0] {
    PRST      = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                 state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   lock_s;
  logic                   relock_s;

  assign lock_s   = sync_r[SYNC_STAGES-1];
  // A relock request during the reset pulse would only restart what is already running.
  assign relock_s = relock_req && (state_r != PRST);

  // Bring the asynchronous PLL lock indication into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pll_locked_async};
    end
  end

  // Sequencer FSM: reset pulse, lock wait with timeout, lock qualification, run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= PRST;
      cnt_r       <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      retry_count <= '0;
    end else if (relock_s) begin
      // Relock outranks timeout and lock loss and never counts as a retry.
      state_r <= PRST;
      cnt_r   <= '0;
      pll_rst <= 1'b1;
      sys_rst <= 1'b1;
      ready   <= 1'b0;
    end else begin
      case (state_r)
        PRST: begin
          if (cnt_r == PRST_LAST) begin
            state_r <= WAIT_LOCK;
            cnt_r   <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_r <= STABLE;
            cnt_r   <= '0;
          end else if (cnt_r == WAIT_LAST) begin
            state_r <= PRST;
            cnt_r   <= '0;
            pll_rst <= 1'b1;
            if (retry_count != RETRY_MAX) begin
              retry_count <= retry_count + RETRY_ONE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            // A dropout restarts the lock wait from scratch; the PLL is not reset.
            state_r <= WAIT_LOCK;
            cnt_r   <= '0;
          end else if (cnt_r == STAB_LAST) begin
            state_r <= RUN;
            cnt_r   <= '0;
            sys_rst <= 1'b0;
            ready   <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_r <= PRST;
            cnt_r   <= '0;
            pll_rst <= 1'b1;
            sys_rst <= 1'b1;
            ready   <= 1'b0;
          end else begin
            cnt_r <= '0;
          end
        end
        default: begin
          state_r <= PRST;
          cnt_r   <= '0;
          pll_rst <= 1'b1;
          sys_rst <= 1'b1;
          ready   <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_PHASE_STEP_EN
  localparam int STEP_W = $clog2(2 * STEP_PULSE);
  localparam logic [STEP_W-1:0] STEP_HI_LAST = STEP_W'(STEP_PULSE - 1);
  localparam logic [STEP_W-1:0] STEP_LAST    = STEP_W'(2 * STEP_PULSE - 1);
  localparam logic [STEP_W-1:0] STEP_ONE     = STEP_W'(1);

  logic [STEP_W-1:0] step_cnt_r;
  logic              leave_run_s;

  assign leave_run_s = (state_r == RUN) && (relock_req || !lock_s);

  // Phase-step handshake: one PHASESTEP high/low pulse per accepted request, only while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt_r    <= '0;
      step_busy     <= 1'b0;
      pll_phasesel  <= 2'b00;
      pll_phasedir  <= 1'b0;
      pll_phasestep <= 1'b0;
    end else if ((state_r != RUN) || leave_run_s) begin
      // Abort any step in flight; select/direction keep their last value.
      step_cnt_r    <= '0;
      step_busy     <= 1'b0;
      pll_phasestep <= 1'b0;
    end else if (step_busy) begin
      if (step_cnt_r == STEP_HI_LAST) begin
        pll_phasestep <= 1'b0;
      end
      if (step_cnt_r == STEP_LAST) begin
        step_busy <= 1'b0;
      end
      step_cnt_r <= step_cnt_r + STEP_ONE;
    end else if (step_req) begin
      step_cnt_r    <= '0;
      step_busy     <= 1'b1;
      pll_phasesel  <= step_sel;
      pll_phasedir  <= step_dir;
      pll_phasestep <= 1'b1;
    end else begin
      step_cnt_r <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer (PLL_RST_CYCLES=4, LOCK_TIMEOUT=32,
// STABLE_CYCLES=8, SYNC_STAGES=2, RETRY_W=2). A hand-derived vector table and
// directed corner sequences are followed by random stimulus compared against a
// phase/elapsed-time reference model. Define PLL_PHASE_STEP_EN to cover stepping.
module tb_pll_lock_sequencer;

  localparam int PRC  = 4;
  localparam int LTO  = 32;
  localparam int STC  = 8;
  localparam int SYNC = 2;
  localparam int SP   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked_async = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [1:0] retry_count;
`ifdef PLL_PHASE_STEP_EN
  logic       step_req = 1'b0;
  logic [1:0] step_sel = 2'b00;
  logic       step_dir = 1'b0;
  logic       step_busy;
  logic [1:0] pll_phasesel;
  logic       pll_phasedir;
  logic       pll_phasestep;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES(PRC),
    .LOCK_TIMEOUT(LTO),
    .STABLE_CYCLES(STC),
    .SYNC_STAGES(SYNC),
    .RETRY_W(2)
`ifdef PLL_PHASE_STEP_EN
    , .STEP_PULSE(SP)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .pll_locked_async(pll_locked_async),
    .relock_req(relock_req),
    .pll_rst(pll_rst),
    .sys_rst(sys_rst),
    .ready(ready),
    .retry_count(retry_count)
`ifdef PLL_PHASE_STEP_EN
    ,
    .step_req(step_req),
    .step_sel(step_sel),
    .step_dir(step_dir),
    .step_busy(step_busy),
    .pll_phasesel(pll_phasesel),
    .pll_phasedir(pll_phasedir),
    .pll_phasestep(pll_phasestep)
`endif
  );

  // ---------------- reference model ----------------
  // Phases are tracked with the edge index at which they were entered; every
  // duration rule is an elapsed-time comparison. The synchroniser is a delay line.
  localparam int PH_PULSE = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_QUAL  = 2;
  localparam int PH_RUN   = 3;

  int m_phase = PH_PULSE;
  int m_enter = 0;
  int m_now   = 0;
  int m_retry = 0;
  bit m_dly[$];
`ifdef PLL_PHASE_STEP_EN
  bit       m_sact = 1'b0;
  int       m_st0 = 0;
  bit [1:0] m_ssel = 2'b00;
  bit       m_sdir = 1'b0;
`endif

  task automatic enter_phase(input int ph);
    m_phase = ph;
    m_enter = m_now;
  endtask

  task automatic model_edge(input bit r, input bit a, input bit rq);
    bit ls;
    int age;
    bit was_run;
    m_now++;
    ls = m_dly[0];
    void'(m_dly.pop_front());
    m_dly.push_back(a);
    age = m_now - m_enter;
    was_run = (m_phase == PH_RUN);
    if (r) begin
      enter_phase(PH_PULSE);
      m_retry = 0;
      m_dly.delete();
      for (int i = 0; i < SYNC; i++) m_dly.push_back(1'b0);
    end else if (rq && m_phase != PH_PULSE) begin
      enter_phase(PH_PULSE);
    end else if (m_phase == PH_PULSE) begin
      if (age == PRC) enter_phase(PH_WAIT);
    end else if (m_phase == PH_WAIT) begin
      if (ls) enter_phase(PH_QUAL);
      else if (age == LTO) begin
        enter_phase(PH_PULSE);
        m_retry = (m_retry < 3) ? m_retry + 1 : 3;
      end
    end else if (m_phase == PH_QUAL) begin
      if (!ls) enter_phase(PH_WAIT);
      else if (age == STC + 1) enter_phase(PH_RUN);
    end else begin
      if (!ls) enter_phase(PH_PULSE);
    end
`ifdef PLL_PHASE_STEP_EN
    if (r) begin
      m_sact = 1'b0;
      m_ssel = 2'b00;
      m_sdir = 1'b0;
    end else if (!was_run || m_phase != PH_RUN) begin
      m_sact = 1'b0;
    end else if (m_sact) begin
      if (m_now - m_st0 == 2 * SP) m_sact = 1'b0;
    end else if (step_req) begin
      m_sact = 1'b1;
      m_st0  = m_now;
      m_ssel = step_sel;
      m_sdir = step_dir;
    end
`endif
  endtask

  // ---------------- drive / check helpers ----------------
  task automatic tick(input bit r, input bit l, input bit rq);
    rst = r;
    pll_locked_async = l;
    relock_req = rq;
    @(posedge clk);
    model_edge(r, l, rq);
    @(negedge clk);
  endtask

  task automatic ticks(input int n, input bit l);
    for (int i = 0; i < n; i++) tick(1'b0, l, 1'b0);
  endtask

  task automatic check_out(input string nm, input bit ep, input bit es, input bit er, input int ert);
    nvec++;
    if (pll_rst !== ep || sys_rst !== es || ready !== er || retry_count !== 2'(ert)) begin
      nerr++;
      $display("FAIL %s: got pll_rst=%0b sys_rst=%0b ready=%0b retry=%0d, want pll_rst=%0b sys_rst=%0b ready=%0b retry=%0d",
               nm, pll_rst, sys_rst, ready, retry_count, ep, es, er, ert);
    end
  endtask

`ifdef PLL_PHASE_STEP_EN
  task automatic check_step(input string nm, input bit eb, input bit eps, input bit [1:0] esel, input bit edir);
    nvec++;
    if (step_busy !== eb || pll_phasestep !== eps || pll_phasesel !== esel || pll_phasedir !== edir) begin
      nerr++;
      $display("FAIL %s: got busy=%0b step=%0b sel=%0d dir=%0b, want busy=%0b step=%0b sel=%0d dir=%0b",
               nm, step_busy, pll_phasestep, pll_phasesel, pll_phasedir, eb, eps, esel, edir);
    end
  endtask
`endif

  typedef struct {
    bit r;
    bit l;
    bit rq;
    int n;
    bit ep;
    bit es;
    bit er;
    int ert;
  } vec_t;

  vec_t tbl[25];

  initial begin
    bit lv;
    bit rqv;
    bit rv;
    for (int i = 0; i < SYNC; i++) m_dly.push_back(1'b0);

    // Segments applied back to back; expectations hold after the last cycle of each.
    tbl[0]  = '{1'b1, 1'b0, 1'b0,  3, 1'b1, 1'b1, 1'b0, 0};  // in reset
    tbl[1]  = '{1'b0, 1'b0, 1'b0,  3, 1'b1, 1'b1, 1'b0, 0};  // pulse cycles 0-2
    tbl[2]  = '{1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b1, 1'b0, 0};  // pulse ends after cycle 3
    tbl[3]  = '{1'b0, 1'b0, 1'b0,  6, 1'b0, 1'b1, 1'b0, 0};  // waiting
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b1, 1'b0, 0};  // lock sampled at cycle 10
    tbl[5]  = '{1'b0, 1'b1, 1'b0,  1, 1'b0, 1'b1, 1'b0, 0};  // 10 cycles after lock
    tbl[6]  = '{1'b0, 1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b1, 0};  // 11 cycles: released
    tbl[7]  = '{1'b0, 1'b1, 1'b0,  5, 1'b0, 1'b0, 1'b1, 0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1,  1, 1'b1, 1'b1, 1'b0, 0};  // relock in RUN
    tbl[9]  = '{1'b0, 1'b1, 1'b0,  3, 1'b1, 1'b1, 1'b0, 0};
    tbl[10] = '{1'b0, 1'b1, 1'b0,  1, 1'b0, 1'b1, 1'b0, 0};
    tbl[11] = '{1'b0, 1'b1, 1'b0,  1, 1'b0, 1'b1, 1'b0, 0};
    tbl[12] = '{1'b0, 1'b1, 1'b0,  8, 1'b0, 1'b1, 1'b0, 0};
    tbl[13] = '{1'b0, 1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b1, 0};  // back in RUN, no retry
    tbl[14] = '{1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b1, 0};  // lock drop in sync chain
    tbl[15] = '{1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b1, 0};
    tbl[16] = '{1'b0, 1'b0, 1'b0,  1, 1'b1, 1'b1, 1'b0, 0};  // lock loss seen
    tbl[17] = '{1'b0, 1'b0, 1'b0,  3, 1'b1, 1'b1, 1'b0, 0};
    tbl[18] = '{1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b1, 1'b0, 0};  // 4-cycle pulse done
    tbl[19] = '{1'b0, 1'b0, 1'b0, 31, 1'b0, 1'b1, 1'b0, 0};
    tbl[20] = '{1'b0, 1'b0, 1'b0,  1, 1'b1, 1'b1, 1'b0, 1};  // first timeout
    tbl[21] = '{1'b0, 1'b0, 1'b0, 36, 1'b1, 1'b1, 1'b0, 2};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 36, 1'b1, 1'b1, 1'b0, 3};
    tbl[23] = '{1'b0, 1'b0, 1'b0, 36, 1'b1, 1'b1, 1'b0, 3};  // saturated
    tbl[24] = '{1'b1, 1'b0, 1'b0,  1, 1'b1, 1'b1, 1'b0, 0};  // reset clears retries

    for (int i = 0; i < 25; i++) begin
      for (int k = 0; k < tbl[i].n; k++) tick(tbl[i].r, tbl[i].l, tbl[i].rq);
      check_out($sformatf("table[%0d]", i), tbl[i].ep, tbl[i].es, tbl[i].er, tbl[i].ert);
    end

    // relock_req during the reset pulse must not stretch it
    tick(1'b1, 1'b0, 1'b0);
    ticks(2, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    check_out("relock_in_prst", 1'b1, 1'b1, 1'b0, 0);
    tick(1'b0, 1'b0, 1'b0);
    check_out("relock_in_prst_end", 1'b0, 1'b1, 1'b0, 0);

    // one-cycle lock glitch at qualification count 5, then 8 fresh cycles
    tick(1'b1, 1'b0, 1'b0);
    ticks(8, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    ticks(10, 1'b1);
    check_out("glitch_hold", 1'b0, 1'b1, 1'b0, 0);
    tick(1'b0, 1'b1, 1'b0);
    check_out("glitch_pre_release", 1'b0, 1'b1, 1'b0, 0);
    tick(1'b0, 1'b1, 1'b0);
    check_out("glitch_release", 1'b0, 1'b0, 1'b1, 0);

    // timeout and relock on the same cycle: relock wins, no retry
    tick(1'b1, 1'b0, 1'b0);
    ticks(35, 1'b0);
    check_out("pre_timeout", 1'b0, 1'b1, 1'b0, 0);
    tick(1'b0, 1'b0, 1'b1);
    check_out("timeout_vs_relock", 1'b1, 1'b1, 1'b0, 0);
    ticks(4, 1'b0);
    check_out("timeout_vs_relock_pulse", 1'b0, 1'b1, 1'b0, 0);

    // reset asserted mid-qualification after one retry
    tick(1'b1, 1'b0, 1'b0);
    ticks(36, 1'b0);
    check_out("retry_one", 1'b1, 1'b1, 1'b0, 1);
    ticks(6, 1'b1);
    check_out("in_stable", 1'b0, 1'b1, 1'b0, 1);
    tick(1'b1, 1'b1, 1'b0);
    check_out("rst_mid_stable", 1'b1, 1'b1, 1'b0, 0);

`ifdef PLL_PHASE_STEP_EN
    // one phase step in RUN; a second request while busy is ignored
    check_step("step_reset", 1'b0, 1'b0, 2'd0, 1'b0);
    ticks(14, 1'b1);
    check_out("step_in_run", 1'b0, 1'b0, 1'b1, 0);
    step_req = 1'b1; step_sel = 2'd2; step_dir = 1'b1;
    tick(1'b0, 1'b1, 1'b0);
    check_step("step_accept", 1'b1, 1'b1, 2'd2, 1'b1);
    step_sel = 2'd1; step_dir = 1'b0;
    ticks(3, 1'b1);
    check_step("step_high", 1'b1, 1'b1, 2'd2, 1'b1);
    step_req = 1'b0;
    tick(1'b0, 1'b1, 1'b0);
    check_step("step_low", 1'b1, 1'b0, 2'd2, 1'b1);
    ticks(3, 1'b1);
    check_step("step_low_end", 1'b1, 1'b0, 2'd2, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    check_step("step_done", 1'b0, 1'b0, 2'd2, 1'b1);
`endif

    // randomized run against the reference model
    tick(1'b1, 1'b0, 1'b0);
    lv = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (lv) lv = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
      else    lv = ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0;
      rqv = ($urandom_range(0, 149) == 0);
      rv  = ($urandom_range(0, 499) == 0);
`ifdef PLL_PHASE_STEP_EN
      step_req = ($urandom_range(0, 9) == 0);
      step_sel = 2'($urandom_range(0, 3));
      step_dir = 1'($urandom_range(0, 1));
`endif
      tick(rv, lv, rqv);
      check_out($sformatf("random[%0d]", c), m_phase == PH_PULSE, m_phase != PH_RUN,
                m_phase == PH_RUN, m_retry);
`ifdef PLL_PHASE_STEP_EN
      check_step($sformatf("random_step[%0d]", c), m_sact,
                 m_sact && ((m_now - m_st0) < SP), m_ssel, m_sdir);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
